ctrl_fsm: RTL and testbench
===========================

Name: ctrl_fsm

Overview:
Parametrised multi-cycle control unit for the RV64-subset CPU. It sequences fetch, decode, execute, memory and write-back. It drives the RAM, PC, IR, register-file and ALU control strobes. New relative to the first-generation controller:
- async reset;
- RAM ready handshake with timeout;
- configurable store strobe timing;
- BEQ/BNE/JAL control flow;
- illegal-instruction trap;
- all strobes defaulted low in every state, with no held-over values between states.

Parameters:
OP_W, 8, width of alu_op
WR_SETUP, 1, cycles ram_cs held low before the store strobe (1..15)
WR_PULSE, 1, cycles ram_cs held high during the store strobe (1..15)
MEM_TIMEOUT, 15, max cycles waiting on ram_ready before bus error (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
instr  in  32  IR contents (valid from DECODE onward)
ram_ready  in  1  RAM read data valid / write accepted
alu_zero  in  1  ALU result == 0
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_oe  out  1  RAM output enable
pc_en  out  1  PC update strobe
pc_in_dir  out  2  PC source: 00 pc+4, 01 pc+imm_b, 10 pc+imm_j, 11 reserved
pc_sign  out  1  1: offset relative to current instruction (datapath subtracts 4)
ir_en  out  1  IR load strobe
reg_en  out  1  regfile enable
reg_we  out  1  regfile write
reg_in_dir  out  2  rd source: 01 RAM, 10 ALU, 11 pc+4
alu_en  out  1  ALU enable
alu_op  out  OP_W  ALU operation code
op2_dir  out  2  op2 source: 00 x[rs2], 01 imm_u, 10 imm_i
illegal  out  1  sticky: undecodable instruction
bus_err  out  1  sticky: RAM timeout

Behaviour:
- Reset (async, any state): state=FETCH, wait counter=0, every output 0. This includes mid-store: ram_cs and ram_we drop immediately.
- All outputs are Moore, decoded from state, defaulting to 0. The one exception is pc_en in FETCH, which is Mealy: (state==FETCH)&ram_ready.
- States and transitions:
  - FETCH: ram_cs=ram_oe=1. On ram_ready go to DECODE. After MEM_TIMEOUT cycles without ready go to TRAP with bus_err=1.
  - DECODE: ir_en=1. Next state is chosen from instr in the following priority order:
    - ADDI (000/0010011)
    - R-type 0110011: ADD/SUB/SLL/SRL/XOR/OR/AND by funct7/funct3
    - MUL/DIV
    - LUI
    - LD (011/0000011)
    - SD (011/0100011)
    - BEQ/BNE (000,001/1100011)
    - JAL (1101111)
    - Anything else goes to TRAP with illegal=1.
  - EXEC: alu_en=1, with alu_op/op2_dir per class: ADDI op2=10, LUI op2=01, branch uses SUB with op2=00.
    - ALU classes go to WB.
    - Branches go to BR.
  - WB: reg_en=reg_we=1, reg_in_dir=10. Go to FETCH.
  - MEM_RD: ram_cs=ram_oe=1; waits on ram_ready with timeout as in FETCH. Go to LD_WB.
  - LD_WB: reg_en=reg_we=1, reg_in_dir=01. Go to FETCH.
  - ST_SETUP: ram_we=1, ram_cs=0, for WR_SETUP cycles.
  - ST_PULSE: ram_we=ram_cs=1, for WR_PULSE cycles.
  - ST_HOLD: ram_we=1, ram_cs=0, 1 cycle. Go to FETCH.
  - BR: if (BEQ & alu_zero) | (BNE & !alu_zero), then pc_en=1, pc_in_dir=01, pc_sign=1. Go to FETCH.
  - JMP (JAL): reg_en=reg_we=1, reg_in_dir=11, pc_en=1, pc_in_dir=10, pc_sign=1. Go to FETCH.
  - TRAP: absorbing until rst. All strobes 0; illegal/bus_err held.
- Latency, with ram_ready=1 in the first FETCH cycle:
  - ALU ops: 4 cycles.
  - LD: 4 cycles + read wait.
  - SD: 3+WR_SETUP+WR_PULSE cycles.
  - Branch: 4 cycles.
  - JAL: 3 cycles.
- The wait counter is 8 bits and clears on every state change. Timeout fires on the cycle count == MEM_TIMEOUT; it never wraps.
- instr changing in a state other than DECODE is ignored.

Optional Feature:
MULDIV_EN.
- Defined: MUL (funct7=0000001, funct3=000) and DIV (funct3=100) decode to EXEC with alu_op OP_MUL/OP_DIV.
- Undefined: both encodings go to TRAP with illegal=1.

Decomposition:
- Package ctrl_pkg holds:
  - state enum;
  - opcode/funct3/funct7 constants;
  - alu_op codes OP_ADD..OP_LUI in the existing 8-bit encoding (ADD=0 … LUI=11), plus OP_MUL/OP_DIV;
  - pc_in_dir/reg_in_dir/op2_dir encodings.
- Sub-module ctrl_decode: combinational, instr -> {class, alu_op, op2_dir, branch_ne}.
- ctrl_fsm holds the state register, wait counter and output decode.

Test Plan:
- ADD x3,x1,x2 = 0x002081B3, ram_ready=1 -> reg_we high exactly in cycle 4 with reg_in_dir=10; alu_op=0 with alu_en in cycle 3.
- BEQ x0,x0,+8 = 0x00000463, alu_zero=1 -> BR cycle shows pc_en=1, pc_in_dir=01, pc_sign=1. With alu_zero=0 -> pc_en=0 in BR.
- SD x2,0(x1) = 0x0020B023, WR_SETUP=2, WR_PULSE=3 -> ram_we high 6 cycles; ram_cs high exactly 3 consecutive cycles; reset asserted during ST_PULSE drops ram_cs same cycle.
- FETCH with ram_ready held 0, MEM_TIMEOUT=15 -> bus_err=1 after 15 cycles, FSM stays in TRAP until rst.
- 0xFFFFFFFF fetched -> illegal=1 the cycle after DECODE, no reg_we/pc_en ever asserted.
- MUL x3,x1,x2 = 0x022081B3 -> with MULDIV_EN: alu_op=OP_MUL then reg_we; without: illegal=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multi-cycle CPU controller.
// Optional MUL/DIV decode is enabled by defining MULDIV_EN.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB, S_MEM_RD, S_LD_WB,
    S_ST_SETUP, S_ST_PULSE, S_ST_HOLD, S_BR, S_JMP, S_TRAP
  } state_t;

  typedef enum logic [2:0] {CL_ALU, CL_LD, CL_SD, CL_BR, CL_JAL, CL_ILL} iclass_t;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_DW  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_MUL = 3'b000;
  localparam logic [2:0] F3_DIV = 3'b100;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU codes keep the first-generation 8-bit numbering
  localparam logic [7:0] OP_ADD = 8'd0;
  localparam logic [7:0] OP_SUB = 8'd1;
  localparam logic [7:0] OP_SLL = 8'd2;
  localparam logic [7:0] OP_XOR = 8'd5;
  localparam logic [7:0] OP_SRL = 8'd6;
  localparam logic [7:0] OP_OR  = 8'd8;
  localparam logic [7:0] OP_AND = 8'd9;
  localparam logic [7:0] OP_LUI = 8'd11;
  localparam logic [7:0] OP_MUL = 8'd12;
  localparam logic [7:0] OP_DIV = 8'd13;

  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] RD_RAM    = 2'b01;
  localparam logic [1:0] RD_ALU    = 2'b10;
  localparam logic [1:0] RD_LINK   = 2'b11;
  localparam logic [1:0] OP2_RS2   = 2'b00;
  localparam logic [1:0] OP2_IMM_U = 2'b01;
  localparam logic [1:0] OP2_IMM_I = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction classifier for ctrl_fsm.
// MUL/DIV are accepted only when MULDIV_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     iclass,
  output logic [7:0]  alu_op,
  output logic [1:0]  op2_dir,
  output logic        branch_ne
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    iclass    = CL_ILL;
    alu_op    = OP_ADD;
    op2_dir   = OP2_RS2;
    branch_ne = 1'b0;
    if (opc == OPC_OPIMM && f3 == F3_ADD) begin
      iclass  = CL_ALU;
      op2_dir = OP2_IMM_I;
    end else if (opc == OPC_OP && f7 == F7_BASE) begin
      iclass = CL_ALU;
      case (f3)
        F3_ADD:  alu_op = OP_ADD;
        F3_SLL:  alu_op = OP_SLL;
        F3_XOR:  alu_op = OP_XOR;
        F3_SRL:  alu_op = OP_SRL;
        F3_OR:   alu_op = OP_OR;
        F3_AND:  alu_op = OP_AND;
        default: iclass = CL_ILL;
      endcase
    end else if (opc == OPC_OP && f7 == F7_ALT && f3 == F3_ADD) begin
      iclass = CL_ALU;
      alu_op = OP_SUB;
`ifdef MULDIV_EN
    end else if (opc == OPC_OP && f7 == F7_MULDIV && (f3 == F3_MUL || f3 == F3_DIV)) begin
      iclass = CL_ALU;
      alu_op = (f3 == F3_MUL) ? OP_MUL : OP_DIV;
`endif
    end else if (opc == OPC_LUI) begin
      iclass  = CL_ALU;
      alu_op  = OP_LUI;
      op2_dir = OP2_IMM_U;
    end else if (opc == OPC_LOAD && f3 == F3_DW) begin
      iclass = CL_LD;
    end else if (opc == OPC_STORE && f3 == F3_DW) begin
      iclass = CL_SD;
    end else if (opc == OPC_BRANCH && (f3 == F3_BEQ || f3 == F3_BNE)) begin
      iclass    = CL_BR;
      alu_op    = OP_SUB;
      branch_ne = (f3 == F3_BNE);
    end else if (opc == OPC_JAL) begin
      iclass = CL_JAL;
    end
  end

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle fetch/decode/execute/memory/write-back controller.
// Defining MULDIV_EN lets the decoder accept MUL and DIV.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 8,
  parameter int WR_SETUP    = 1,
  parameter int WR_PULSE    = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            ram_ready,
  input  logic            alu_zero,
  output logic            ram_cs,
  output logic            ram_we,
  output logic            ram_oe,
  output logic            pc_en,
  output logic [1:0]      pc_in_dir,
  output logic            pc_sign,
  output logic            ir_en,
  output logic            reg_en,
  output logic            reg_we,
  output logic [1:0]      reg_in_dir,
  output logic            alu_en,
  output logic [OP_W-1:0] alu_op,
  output logic [1:0]      op2_dir,
  output logic            illegal,
  output logic            bus_err
);

  localparam logic [7:0] TMO_LAST   = 8'(MEM_TIMEOUT - 1);
  localparam logic [7:0] SETUP_LAST = 8'(WR_SETUP - 1);
  localparam logic [7:0] PULSE_LAST = 8'(WR_PULSE - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  iclass_t    dec_class, cls_q;
  logic [7:0] dec_op, op_q;
  logic [1:0] dec_op2, op2_q;
  logic       dec_ne, ne_q;
  logic       illegal_q, bus_err_q;

  ctrl_decode u_decode (
    .instr     (instr),
    .iclass    (dec_class),
    .alu_op    (dec_op),
    .op2_dir   (dec_op2),
    .branch_ne (dec_ne)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (ram_ready) state_nxt = S_DECODE;
                  else if (wait_cnt == TMO_LAST) state_nxt = S_TRAP;
      S_DECODE: begin
        case (dec_class)
          CL_ALU, CL_BR: state_nxt = S_EXEC;
          CL_LD:         state_nxt = S_MEM_RD;
          CL_SD:         state_nxt = S_ST_SETUP;
          CL_JAL:        state_nxt = S_JMP;
          default:       state_nxt = S_TRAP;
        endcase
      end
      S_EXEC:     state_nxt = (cls_q == CL_BR) ? S_BR : S_WB;
      S_MEM_RD:   if (ram_ready) state_nxt = S_LD_WB;
                  else if (wait_cnt == TMO_LAST) state_nxt = S_TRAP;
      S_ST_SETUP: if (wait_cnt == SETUP_LAST) state_nxt = S_ST_PULSE;
      S_ST_PULSE: if (wait_cnt == PULSE_LAST) state_nxt = S_ST_HOLD;
      S_WB, S_LD_WB, S_ST_HOLD, S_BR, S_JMP: state_nxt = S_FETCH;
      default:    state_nxt = state;
    endcase
  end

  // Decoder results are captured in DECODE so later changes on instr are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= 8'd0;
      cls_q     <= CL_ILL;
      op_q      <= 8'd0;
      op2_q     <= 2'b00;
      ne_q      <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)   wait_cnt <= 8'd0;
      else if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      if (state == S_DECODE) begin
        cls_q <= dec_class;
        op_q  <= dec_op;
        op2_q <= dec_op2;
        ne_q  <= dec_ne;
        if (state_nxt == S_TRAP) illegal_q <= 1'b1;
      end
      if ((state == S_FETCH || state == S_MEM_RD) && state_nxt == S_TRAP) bus_err_q <= 1'b1;
    end
  end

  // Outputs are forced low while rst is held so a store aborts immediately
  always_comb begin
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_oe     = 1'b0;
    pc_en      = 1'b0;
    pc_in_dir  = 2'b00;
    pc_sign    = 1'b0;
    ir_en      = 1'b0;
    reg_en     = 1'b0;
    reg_we     = 1'b0;
    reg_in_dir = 2'b00;
    alu_en     = 1'b0;
    alu_op     = '0;
    op2_dir    = 2'b00;
    illegal    = illegal_q;
    bus_err    = bus_err_q;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ram_cs = 1'b1;
          ram_oe = 1'b1;
          pc_en  = ram_ready;
        end
        S_DECODE: ir_en = 1'b1;
        S_EXEC: begin
          alu_en  = 1'b1;
          alu_op  = OP_W'(op_q);
          op2_dir = op2_q;
        end
        S_WB: begin
          reg_en     = 1'b1;
          reg_we     = 1'b1;
          reg_in_dir = RD_ALU;
        end
        S_MEM_RD: begin
          ram_cs = 1'b1;
          ram_oe = 1'b1;
        end
        S_LD_WB: begin
          reg_en     = 1'b1;
          reg_we     = 1'b1;
          reg_in_dir = RD_RAM;
        end
        S_ST_SETUP, S_ST_HOLD: ram_we = 1'b1;
        S_ST_PULSE: begin
          ram_we = 1'b1;
          ram_cs = 1'b1;
        end
        S_BR: begin
          if (ne_q ? !alu_zero : alu_zero) begin
            pc_en     = 1'b1;
            pc_in_dir = PC_BRANCH;
            pc_sign   = 1'b1;
          end
        end
        S_JMP: begin
          reg_en     = 1'b1;
          reg_we     = 1'b1;
          reg_in_dir = RD_LINK;
          pc_en      = 1'b1;
          pc_in_dir  = PC_JUMP;
          pc_sign    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - table-driven bench for ctrl_fsm with multi-cycle corner sequences.
module tb_ctrl_fsm;

  logic        clk, rst, ram_ready, alu_zero;
  logic [31:0] instr;
  logic        ram_cs, ram_we, ram_oe, pc_en, pc_sign, ir_en, reg_en, reg_we, alu_en;
  logic        illegal, bus_err;
  logic [1:0]  pc_in_dir, reg_in_dir, op2_dir;
  logic [7:0]  alu_op;
  logic [24:0] outs_w;

  int total = 0;
  int bad   = 0;

  ctrl_fsm #(.OP_W(8), .WR_SETUP(2), .WR_PULSE(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .ram_ready(ram_ready), .alu_zero(alu_zero),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .pc_en(pc_en),
    .pc_in_dir(pc_in_dir), .pc_sign(pc_sign), .ir_en(ir_en), .reg_en(reg_en),
    .reg_we(reg_we), .reg_in_dir(reg_in_dir), .alu_en(alu_en), .alu_op(alu_op),
    .op2_dir(op2_dir), .illegal(illegal), .bus_err(bus_err)
  );

  assign outs_w = {ram_cs, ram_we, ram_oe, pc_en, pc_in_dir, pc_sign, ir_en, reg_en,
                   reg_we, reg_in_dir, alu_en, alu_op, op2_dir, illegal, bus_err};

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int len, n_alu, op, op2, we_cyc, rdir, n_pc, pdir, psign, n_we, cs_first, cs_last;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ram_ready = rdy;
    #1;
  endtask

  // Entered 1ns after a negedge with the DUT in the first FETCH cycle; returns
  // at the same phase of the next FETCH cycle.
  task automatic run_vec(input vec_t v, input string tag);
    int len = 0, n_alu = 0, op = 0, op2 = 0, we_cyc = 0, rdir = 0;
    int n_pc = 0, pdir = 0, psign = 0, n_we = 0, cs_first = 0, cs_last = 0;
    instr = v.instr;
    alu_zero = v.zero;
    for (int c = 1; c <= 24; c++) begin
      if (c > 1 && ram_cs && ram_oe && pc_en) begin
        len = c - 1;
        break;
      end
      if (alu_en) begin n_alu++; op = int'(alu_op); op2 = int'(op2_dir); end
      if (reg_we) begin we_cyc = c; rdir = int'(reg_in_dir); end
      if (pc_en && !ram_cs) begin n_pc++; pdir = int'(pc_in_dir); psign = int'(pc_sign); end
      if (ram_we) n_we++;
      if (ram_we && ram_cs) begin
        if (cs_first == 0) cs_first = c;
        cs_last = c;
      end
      @(negedge clk);
      #1;
    end
    chk({tag, "_len"}, len, v.len);
    chk({tag, "_alu_en_cnt"}, n_alu, v.n_alu);
    chk({tag, "_alu_op"}, op, v.op);
    chk({tag, "_op2_dir"}, op2, v.op2);
    chk({tag, "_reg_we_cycle"}, we_cyc, v.we_cyc);
    chk({tag, "_reg_in_dir"}, rdir, v.rdir);
    chk({tag, "_pc_en_cnt"}, n_pc, v.n_pc);
    chk({tag, "_pc_in_dir"}, pdir, v.pdir);
    chk({tag, "_pc_sign"}, psign, v.psign);
    chk({tag, "_ram_we_cnt"}, n_we, v.n_we);
    chk({tag, "_cs_first"}, cs_first, v.cs_first);
    chk({tag, "_cs_last"}, cs_last, v.cs_last);
  endtask

  task automatic run_illegal(input logic [31:0] ins, input string tag);
    int ill2 = -1, ill3 = -1, n_bad = 0;
    instr = ins;
    for (int c = 1; c <= 12; c++) begin
      if (c >= 2 && (reg_we || pc_en)) n_bad++;
      if (c == 2) ill2 = int'(illegal);
      if (c == 3) ill3 = int'(illegal);
      if (c < 12) begin
        @(negedge clk);
        #1;
      end
    end
    chk({tag, "_illegal_in_decode"}, ill2, 0);
    chk({tag, "_illegal_after"}, ill3, 1);
    chk({tag, "_stray_strobes"}, n_bad, 0);
    chk({tag, "_trap_cs"}, int'(ram_cs), 0);
  endtask

  initial begin
    int found, n_ok, n_ir;
    vec_t mulv;
    clk = 1'b0;
    rst = 1'b1;
    instr = 32'h0;
    ram_ready = 1'b1;
    alu_zero = 1'b0;

    //           instr          z  len alu op op2 we rd  pc pd ps nwe csf csl
    vecs[0]  = '{32'h002081B3, 1'b0, 4, 1,  0, 0, 4, 2, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{32'h00500093, 1'b0, 4, 1,  0, 2, 4, 2, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{32'h402081B3, 1'b0, 4, 1,  1, 0, 4, 2, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{32'h0020C1B3, 1'b0, 4, 1,  5, 0, 4, 2, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{32'h0020F1B3, 1'b0, 4, 1,  9, 0, 4, 2, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{32'h002091B3, 1'b0, 4, 1,  2, 0, 4, 2, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{32'h123452B7, 1'b0, 4, 1, 11, 1, 4, 2, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{32'h00000463, 1'b1, 4, 1,  1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    vecs[8]  = '{32'h00000463, 1'b0, 4, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{32'h00001463, 1'b0, 4, 1,  1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    vecs[10] = '{32'h00001463, 1'b1, 4, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{32'h010000EF, 1'b0, 3, 0,  0, 0, 3, 3, 1, 2, 1, 0, 0, 0};
    vecs[12] = '{32'h0000B183, 1'b0, 4, 0,  0, 0, 4, 1, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{32'h0020B023, 1'b0, 8, 0,  0, 0, 0, 0, 0, 0, 0, 6, 5, 7};
    mulv     = '{32'h022081B3, 1'b0, 4, 1, 12, 0, 4, 2, 0, 0, 0, 0, 0, 0};

    @(negedge clk);
    #1;
    chk("reset_outputs", int'(outs_w), 0);

    do_reset(1'b1);
    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset in the middle of the store pulse
    do_reset(1'b1);
    instr = 32'h0020B023;
    found = 0;
    for (int c = 1; c <= 12; c++) begin
      if (ram_cs && ram_we) begin
        found = c;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("st_pulse_first_cycle", found, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_pulse_cs", int'(ram_cs), 0);
    chk("rst_mid_pulse_we", int'(ram_we), 0);

    do_reset(1'b1);
    run_illegal(32'hFFFFFFFF, "allones");

    do_reset(1'b1);
`ifdef MULDIV_EN
    run_vec(mulv, "mul");
`else
    chk("mul_vec_alu_op", int'(mulv.op), 12);
    run_illegal(32'h022081B3, "mul");
`endif

    // FETCH with no ram_ready must time out after exactly 15 cycles
    do_reset(1'b0);
    n_ok = 0;
    for (int c = 1; c <= 15; c++) begin
      if (ram_cs && !bus_err) n_ok++;
      @(negedge clk);
      #1;
    end
    chk("fetch_wait_cycles", n_ok, 15);
    chk("timeout_bus_err", int'(bus_err), 1);
    chk("timeout_trap_cs", int'(ram_cs), 0);
    ram_ready = 1'b1;
    n_ir = 0;
    for (int c = 0; c < 6; c++) begin
      if (ir_en || ram_cs) n_ir++;
      @(negedge clk);
      #1;
    end
    chk("trap_absorbing", n_ir, 0);
    chk("trap_bus_err_held", int'(bus_err), 1);
    rst = 1'b1;
    #1;
    chk("final_reset_outputs", int'(outs_w), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
